// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM states, special-case constants and signedness helpers.
package muldiv_unit_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } md_state_t;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic op_a_signed(input logic [2:0] op);
    return !(op == MD_MULHU || op == MD_DIVU || op == MD_REMU);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MD_MUL || op == MD_MULH || op == MD_DIV || op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Combinational sign handling: operand magnitudes at load time, and sign
// correction plus result-word selection at the end of an operation.
module muldiv_signfix
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]         ld_op,
  input  logic [WIDTH-1:0]   ld_a,
  input  logic [WIDTH-1:0]   ld_b,
  output logic               ld_sign_a,
  output logic               ld_sign_b,
  output logic [WIDTH-1:0]   ld_abs_a,
  output logic [WIDTH-1:0]   ld_abs_b,
  input  logic [2:0]         fix_op,
  input  logic               fix_sign_a,
  input  logic               fix_sign_b,
  input  logic [2*WIDTH-1:0] prod,
  input  logic [WIDTH-1:0]   quo,
  input  logic [WIDTH-1:0]   rem,
  output logic [WIDTH-1:0]   result
);

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    ld_sign_a = op_a_signed(ld_op) & ld_a[WIDTH-1];
    ld_sign_b = op_b_signed(ld_op) & ld_b[WIDTH-1];
    ld_abs_a  = ld_sign_a ? (~ld_a + 1'b1) : ld_a;
    ld_abs_b  = ld_sign_b ? (~ld_b + 1'b1) : ld_b;

    // MULHSU never latches sign_b, so one xor covers every multiply flavour
    prod_fix = (fix_sign_a ^ fix_sign_b) ? (~prod + 1'b1) : prod;
    quo_fix  = (fix_sign_a ^ fix_sign_b) ? (~quo + 1'b1) : quo;
    rem_fix  = fix_sign_a ? (~rem + 1'b1) : rem;

    result = rem_fix;
    case (fix_op)
      MD_MUL:                       result = prod_fix[WIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[2*WIDTH-1:WIDTH];
      MD_DIV, MD_DIVU:              result = quo_fix;
      default:                      result = rem_fix;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle, with a one-cycle sign-fix stage.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic             Kill,
  input  logic [2:0]       MD_Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] MD_Result,
  output md_state_t        dbg_state
);

  // Handshake: Start is taken only in IDLE with Kill low; Busy stays high
  // until the operation retires; Done pulses for one cycle with MD_Result
  // valid, and Kill in any busy state returns to IDLE without a Done.
  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  md_state_t          state;
  logic [2:0]         op_q;
  logic               sa_q, sb_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem_q;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   result_q;
  logic               done_q;

  logic               ld_sign_a, ld_sign_b;
  logic [WIDTH-1:0]   ld_abs_a, ld_abs_b, fix_result;
  logic               div_zero, div_ovf;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .ld_op      (MD_Op),
    .ld_a       (SrcA),
    .ld_b       (SrcB),
    .ld_sign_a  (ld_sign_a),
    .ld_sign_b  (ld_sign_b),
    .ld_abs_a   (ld_abs_a),
    .ld_abs_b   (ld_abs_b),
    .fix_op     (op_q),
    .fix_sign_a (sa_q),
    .fix_sign_b (sb_q),
    .prod       (acc),
    .quo        (acc[WIDTH-1:0]),
    .rem        (rem_q),
    .result     (fix_result)
  );

  always_comb begin
    div_zero  = MD_Op[2] && (SrcB == '0);
    div_ovf   = (MD_Op == MD_DIV || MD_Op == MD_REM) && (SrcA == INT_MIN) && (SrcB == ALL_ONES);
    // multiplier sits in acc's low word and drains out as the product shifts in
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_q} : '0);
    div_shift = {rem_q, acc[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    // when div_ge holds the true difference is below b_q, so WIDTH bits suffice
    div_diff  = div_shift[WIDTH-1:0] - b_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      rem_q    <= '0;
      count    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start && !Kill) begin
            op_q  <= MD_Op;
            sa_q  <= ld_sign_a;
            sb_q  <= ld_sign_b;
            a_q   <= ld_abs_a;
            b_q   <= ld_abs_b;
            acc   <= {{WIDTH{1'b0}}, (MD_Op[2] ? ld_abs_a : ld_abs_b)};
            rem_q <= '0;
            count <= '0;
            if (div_zero) begin
              result_q <= MD_Op[1] ? SrcA : ALL_ONES;
              done_q   <= 1'b1;
              state    <= ST_DONE;
            end else if (div_ovf) begin
              result_q <= MD_Op[1] ? '0 : INT_MIN;
              done_q   <= 1'b1;
              state    <= ST_DONE;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (Kill) begin
            state <= ST_IDLE;
          end else begin
            if (op_q[2]) begin
              acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_ge};
              rem_q          <= div_ge ? div_diff : div_shift[WIDTH-1:0];
            end else begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
            end
            count <= count + 1'b1;
            if (count == LAST) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (Kill) begin
            state <= ST_IDLE;
          end else begin
            result_q <= fix_result;
            done_q   <= 1'b1;
            state    <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Busy      = (state != ST_IDLE);
  assign Done      = done_q & ~Kill;
  assign MD_Result = result_q;
  assign dbg_state = state;

endmodule
